// File: rtl/taxi_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : taxi_dma_pkg
// Description : Shared helpers for the DMA RAM read arbiter: port-index width
//               helper and the round-robin grant function.
// Revision    : 1.0 - initial release
// ============================================================================
package taxi_dma_pkg;

  // Largest port count the grant function is written for.
  localparam int MAX_PORTS = 16;

  // Width of a port index; never narrower than one bit so PORTS=1 still has a tag.
  function automatic int cl_ports(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  // First valid port at or after ptr, wrapping modulo ports. Scanning from the
  // far end lets the closest candidate overwrite earlier ones. With no valid
  // port the pointer itself is returned, which keeps the grant stable.
  function automatic logic [3:0] rr_grant(input logic [MAX_PORTS-1:0] valid,
                                          input logic [3:0]           ptr,
                                          input int                   ports);
    logic [3:0] g;
    int         idx;
    g = ptr;
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      if (i < ports) begin
        idx = (int'(ptr) + i) % ports;
        if (valid[idx]) g = 4'(idx);
      end
    end
    return g;
  endfunction

endpackage : taxi_dma_pkg
`default_nettype wire

// File: rtl/taxi_dma_ram_rd_arb_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : taxi_dma_ram_rd_arb_tag_fifo
// Description : Synchronous FIFO of port tags, one entry per outstanding read.
//               Full blocks push even when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module taxi_dma_ram_rd_arb_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [TAG_W-1:0]       push_tag,
  input  logic                   pop,
  output logic [TAG_W-1:0]       head_tag,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_tag = mem_q[rd_ptr_q];
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Tag storage needs no reset; only valid entries are ever read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : taxi_dma_ram_rd_arb_tag_fifo
`default_nettype wire

// File: rtl/taxi_dma_ram_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : taxi_dma_ram_rd_arb
// Description : Round-robin arbiter sharing one DMA RAM read port between
//               PORTS clients. Commands pass through with zero latency; a tag
//               FIFO steers the in-order responses back to the issuing port.
//               Optional status outputs: define TAXI_DMA_RAM_RD_ARB_STATUS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module taxi_dma_ram_rd_arb
  import taxi_dma_pkg::*;
#(
  parameter int PORTS  = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PORTS*ADDR_W-1:0] req_cmd_addr,
  input  logic [PORTS-1:0]        req_cmd_valid,
  output logic [PORTS-1:0]        req_cmd_ready,
  output logic [PORTS*DATA_W-1:0] req_resp_data,
  output logic [PORTS-1:0]        req_resp_valid,
  input  logic [PORTS-1:0]        req_resp_ready,
  output logic [ADDR_W-1:0]       ram_cmd_addr,
  output logic                    ram_cmd_valid,
  input  logic                    ram_cmd_ready,
  input  logic [DATA_W-1:0]       ram_resp_data,
  input  logic                    ram_resp_valid,
  output logic                    ram_resp_ready
`ifdef TAXI_DMA_RAM_RD_ARB_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0]  stat_outstanding,
  output logic [PORTS-1:0]        stat_port_busy
`endif
);

  localparam int CL_PORTS = cl_ports(PORTS);
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic [CL_PORTS-1:0] rr_ptr_q, rr_ptr_d;
  logic [CL_PORTS-1:0] grant;
  logic [CL_PORTS-1:0] head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic                cmd_fire;
  logic                resp_fire;

  assign grant = CL_PORTS'(rr_grant(MAX_PORTS'(req_cmd_valid), 4'(rr_ptr_q), PORTS));

  // Command path: forward the granted port's address; only it may see ready.
  // Reset also masks the outputs so nothing can handshake while state clears.
  always_comb begin
    ram_cmd_valid = (|req_cmd_valid) & ~fifo_full & ~rst;
    ram_cmd_addr  = '0;
    req_cmd_ready = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (grant == CL_PORTS'(p)) begin
        ram_cmd_addr     = req_cmd_addr[p*ADDR_W +: ADDR_W];
        req_cmd_ready[p] = ram_cmd_ready & ~fifo_full & ~rst;
      end
    end
  end

  // Response path: only the port at the FIFO head sees the RAM response;
  // with an empty FIFO the RAM is never acknowledged, so stray data is held.
  always_comb begin
    req_resp_valid = '0;
    ram_resp_ready = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      if (head == CL_PORTS'(p)) begin
        req_resp_valid[p] = ram_resp_valid & ~fifo_empty & ~rst;
        ram_resp_ready    = req_resp_ready[p] & ~fifo_empty & ~rst;
      end
    end
  end

  assign req_resp_data = {PORTS{ram_resp_data}};
  assign cmd_fire      = ram_cmd_valid & ram_cmd_ready;
  assign resp_fire     = ram_resp_valid & ram_resp_ready;

  // Pointer moves past the winner only on a handshake, so a stalled RAM sees
  // a stable grant and address.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (cmd_fire) begin
      rr_ptr_d = (grant == CL_PORTS'(PORTS - 1)) ? '0 : grant + CL_PORTS'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  taxi_dma_ram_rd_arb_tag_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (CL_PORTS)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cmd_fire),
    .push_tag (grant),
    .pop      (resp_fire),
    .head_tag (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

`ifdef TAXI_DMA_RAM_RD_ARB_STATUS_EN
  logic [CNT_W-1:0] port_cnt_q [PORTS];
  logic [CNT_W-1:0] port_cnt_d [PORTS];
  logic [PORTS-1:0] port_busy_q, port_busy_d;

  // Per-port outstanding counters; busy mirrors the post-update counter.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      port_cnt_d[p] = port_cnt_q[p];
      if ((cmd_fire && grant == CL_PORTS'(p)) && !(resp_fire && head == CL_PORTS'(p))) begin
        port_cnt_d[p] = port_cnt_q[p] + CNT_W'(1);
      end else if (!(cmd_fire && grant == CL_PORTS'(p)) && (resp_fire && head == CL_PORTS'(p))) begin
        port_cnt_d[p] = port_cnt_q[p] - CNT_W'(1);
      end
      port_busy_d[p] = (port_cnt_d[p] != '0);
    end
  end

  // Status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < PORTS; p++) port_cnt_q[p] <= '0;
      port_busy_q <= '0;
    end else begin
      port_cnt_q  <= port_cnt_d;
      port_busy_q <= port_busy_d;
    end
  end

  assign stat_outstanding = fifo_count;
  assign stat_port_busy   = port_busy_q;
`else
  logic unused_count;
  assign unused_count = ^fifo_count;
`endif

endmodule : taxi_dma_ram_rd_arb
`default_nettype wire

// File: tb/tb_taxi_dma_ram_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_taxi_dma_ram_rd_arb
// Description : Scoreboard bench for the DMA RAM read arbiter (PORTS=4,
//               DEPTH=8) with a small in-order RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_taxi_dma_ram_rd_arb;

  localparam int PORTS  = 4;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 8;
  localparam int BIG    = 1000000;

  typedef struct packed {
    logic [3:0]        port;
    logic [DATA_W-1:0] data;
  } resp_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [PORTS*ADDR_W-1:0] req_cmd_addr   = '0;
  logic [PORTS-1:0]        req_cmd_valid  = '0;
  logic [PORTS-1:0]        req_cmd_ready;
  logic [PORTS*DATA_W-1:0] req_resp_data;
  logic [PORTS-1:0]        req_resp_valid;
  logic [PORTS-1:0]        req_resp_ready = '0;
  logic [ADDR_W-1:0]       ram_cmd_addr;
  logic                    ram_cmd_valid;
  logic                    ram_cmd_ready  = 1'b0;
  logic [DATA_W-1:0]       ram_resp_data  = '0;
  logic                    ram_resp_valid = 1'b0;
  logic                    ram_resp_ready;
`ifdef TAXI_DMA_RAM_RD_ARB_STATUS_EN
  logic [$clog2(DEPTH):0]  stat_outstanding;
  logic [PORTS-1:0]        stat_port_busy;
`endif

  always #5 clk = ~clk;

  taxi_dma_ram_rd_arb #(
    .PORTS  (PORTS),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_cmd_addr   (req_cmd_addr),
    .req_cmd_valid  (req_cmd_valid),
    .req_cmd_ready  (req_cmd_ready),
    .req_resp_data  (req_resp_data),
    .req_resp_valid (req_resp_valid),
    .req_resp_ready (req_resp_ready),
    .ram_cmd_addr   (ram_cmd_addr),
    .ram_cmd_valid  (ram_cmd_valid),
    .ram_cmd_ready  (ram_cmd_ready),
    .ram_resp_data  (ram_resp_data),
    .ram_resp_valid (ram_resp_valid),
    .ram_resp_ready (ram_resp_ready)
`ifdef TAXI_DMA_RAM_RD_ARB_STATUS_EN
    ,
    .stat_outstanding (stat_outstanding),
    .stat_port_busy   (stat_port_busy)
`endif
  );

  // ---------------------------------------------------------------- state
  int                n_vec = 0;
  int                n_err = 0;
  logic [ADDR_W-1:0] port_q [PORTS][$];
  logic [ADDR_W-1:0] ram_q [$];
  logic [ADDR_W-1:0] exp_cmd [$];
  resp_t             exp_resp [$];
  int                resp_budget  = BIG;
  logic              cmd_rdy_knob = 1'b1;
  logic [PORTS-1:0]  rdy_knob     = '1;
  logic              cmd_hs_now   = 1'b0;
  logic              resp_hs_now  = 1'b0;
  logic [ADDR_W-1:0] cmd_addr_now = '0;
  logic [PORTS-1:0]  port_fire    = '0;
  int                n_cmd = 0;
  int                n_resp = 0;
  int                outst = 0;

  function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
    return {16'hD00D, ~a, 16'h5A5A, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic issue(input int p, input logic [ADDR_W-1:0] a);
    port_q[p].push_back(a);
  endtask

  task automatic expect_cmd(input int p, input logic [ADDR_W-1:0] a, input bit with_resp);
    resp_t r;
    exp_cmd.push_back(a);
    if (with_resp) begin
      r.port = 4'(p);
      r.data = ram_word(a);
      exp_resp.push_back(r);
    end
  endtask

  task automatic wait_cmds(input string name);
    int n = 0;
    while (exp_cmd.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #2;
    check(name, 64'(exp_cmd.size() == 0), 64'd1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_cmd.size() != 0 || exp_resp.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #2;
    check(name, 64'(exp_cmd.size() + exp_resp.size()), 64'd0);
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin
    logic          c, r;
    logic [PORTS-1:0] pf, rv;
    resp_t         e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        c  = ram_cmd_valid && ram_cmd_ready;
        r  = ram_resp_valid && ram_resp_ready;
        pf = req_cmd_valid & req_cmd_ready;
        rv = req_resp_valid & req_resp_ready;
        if (c) begin
          check("cmd_expected", 64'(exp_cmd.size() != 0), 64'd1);
          check("cmd_port_hs_onehot", 64'($countones(pf)), 64'd1);
          if (exp_cmd.size() != 0) check("cmd_addr", 64'(ram_cmd_addr), 64'(exp_cmd.pop_front()));
        end
        if (r || rv != '0) begin
          check("resp_expected", 64'(exp_resp.size() != 0), 64'd1);
          if (exp_resp.size() != 0) begin
            e = exp_resp.pop_front();
            check("resp_route", 64'({r, rv}), 64'({1'b1, 4'(4'd1 << e.port)}));
            check("resp_data", req_resp_data[int'(e.port)*DATA_W +: DATA_W], e.data);
          end
        end
`ifdef TAXI_DMA_RAM_RD_ARB_STATUS_EN
        check("stat_outstanding", 64'(stat_outstanding), 64'(outst));
`endif
        cmd_hs_now   = c;
        resp_hs_now  = r;
        cmd_addr_now = ram_cmd_addr;
        port_fire    = pf;
        n_cmd        = n_cmd + int'(c);
        n_resp       = n_resp + int'(r);
      end else begin
        cmd_hs_now  = 1'b0;
        resp_hs_now = 1'b0;
        port_fire   = '0;
      end
    end
  end

  // ------------------------------------------------- client + RAM drivers
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        ram_q.delete();
        outst = 0;
      end else begin
        for (int p = 0; p < PORTS; p++) begin
          if (port_fire[p] && port_q[p].size() != 0) void'(port_q[p].pop_front());
        end
        if (cmd_hs_now) ram_q.push_back(cmd_addr_now);
        if (resp_hs_now) begin
          if (ram_q.size() != 0) void'(ram_q.pop_front());
          if (resp_budget > 0) resp_budget--;
        end
        outst = outst + int'(cmd_hs_now) - int'(resp_hs_now);
      end
      for (int p = 0; p < PORTS; p++) begin
        req_cmd_valid[p] = (port_q[p].size() != 0);
        req_cmd_addr[p*ADDR_W +: ADDR_W] = (port_q[p].size() != 0) ? port_q[p][0] : '0;
      end
      ram_cmd_ready  = cmd_rdy_knob;
      ram_resp_valid = (ram_q.size() != 0) && (resp_budget > 0);
      ram_resp_data  = (ram_q.size() != 0) ? ram_word(ram_q[0]) : '0;
      req_resp_ready = rdy_knob;
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int base;
    int rbase;

    // Round-robin traffic queued up while still in reset: all four ports valid.
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < PORTS; p++) begin
        issue(p, 16'((p + 1) * 4096 + k));
        expect_cmd(p, 16'((p + 1) * 4096 + k), 1'b1);
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ram_cmd_valid", 64'(ram_cmd_valid), 64'd0);
    check("rst_req_cmd_ready", 64'(req_cmd_ready), 64'd0);
    check("rst_req_resp_valid", 64'(req_resp_valid), 64'd0);
    check("rst_ram_resp_ready", 64'(ram_resp_ready), 64'd0);

    // 1. Fairness: 12 commands in 12 consecutive cycles, grants 0,1,2,3,...
    @(posedge clk); #2;
    base = n_cmd;
    rst  = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    check("rr_one_per_cycle", 64'(n_cmd - base), 64'd12);
    wait_drain("rr_drain");

    // 2. Backpressure: port 2 wins over port 3 and holds while RAM stalls.
    @(posedge clk); #2;
    cmd_rdy_knob = 1'b0;
    issue(2, 16'h2222); expect_cmd(2, 16'h2222, 1'b1);
    issue(3, 16'h3333); expect_cmd(3, 16'h3333, 1'b1);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_addr", 64'(ram_cmd_addr), 64'h2222);
      check("hold_valid_ready", 64'({ram_cmd_valid, req_cmd_ready}), 64'b1_0000);
    end
    @(posedge clk); #2;
    cmd_rdy_knob = 1'b1;
    wait_drain("hold_drain");

    // 3. Full stall: 10 offered, 8 accepted, one response frees one slot.
    @(posedge clk); #2;
    resp_budget = 0;
    for (int k = 0; k < 5; k++) begin
      issue(0, 16'(16'h3000 + k)); expect_cmd(0, 16'(16'h3000 + k), 1'b1);
      issue(1, 16'(16'h3100 + k)); expect_cmd(1, 16'(16'h3100 + k), 1'b1);
    end
    base  = n_cmd;
    rbase = n_resp;
    repeat (15) @(posedge clk);
    #2;
    check("full_issued", 64'(n_cmd - base), 64'd8);
    @(negedge clk);
    check("full_cmd_valid", 64'(ram_cmd_valid), 64'd0);
    @(posedge clk); #2;
    resp_budget = 1;
    repeat (5) @(posedge clk);
    #2;
    check("full_one_more", 64'(n_cmd - base), 64'd9);
    check("full_one_resp", 64'(n_resp - rbase), 64'd1);
    @(negedge clk);
    check("full_cmd_valid_again", 64'(ram_cmd_valid), 64'd0);
    @(posedge clk); #2;
    resp_budget = BIG;
    wait_drain("full_drain");

    // 4. Steering with stall: order 1,0,1 and port 0 not ready.
    @(posedge clk); #2;
    resp_budget = 0;
    rdy_knob    = 4'b1110;
    issue(1, 16'h4001); expect_cmd(1, 16'h4001, 1'b1);
    wait_cmds("steer_cmd_a");
    issue(0, 16'h4000); expect_cmd(0, 16'h4000, 1'b1);
    wait_cmds("steer_cmd_b");
    issue(1, 16'h4002); expect_cmd(1, 16'h4002, 1'b1);
    wait_cmds("steer_cmd_c");
    @(posedge clk); #2;
    resp_budget = BIG;
    for (int n = 0; n < 50 && exp_resp.size() != 2; n++) @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("steer_held_ready", 64'(ram_resp_ready), 64'd0);
      check("steer_held_valid", 64'(req_resp_valid), 64'b0001);
    end
    @(posedge clk); #2;
    rdy_knob = '1;
    wait_drain("steer_drain");

    // 5. Push and pop together at count 3.
    @(posedge clk); #2;
    resp_budget = 0;
    issue(2, 16'h5002); expect_cmd(2, 16'h5002, 1'b1);
    issue(3, 16'h5003); expect_cmd(3, 16'h5003, 1'b1);
    issue(0, 16'h5000); expect_cmd(0, 16'h5000, 1'b1);
    wait_cmds("pp_fill");
    @(posedge clk); #2;
    check("pp_outstanding", 64'(outst), 64'd3);
    for (int k = 1; k <= 3; k++) begin
      issue(1, 16'(16'h5100 + k)); expect_cmd(1, 16'(16'h5100 + k), 1'b1);
    end
    resp_budget = BIG;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("pp_both_hs", 64'({cmd_hs_now, resp_hs_now}), 64'b11);
      check("pp_count", 64'(outst), 64'd3);
    end
    wait_drain("pp_drain");

    // 6. Reset with 4 reads outstanding; pointer returns to port 0.
    @(posedge clk); #2;
    resp_budget = 0;
    issue(0, 16'h6000); issue(1, 16'h6001); issue(2, 16'h6002); issue(3, 16'h6003);
    expect_cmd(2, 16'h6002, 1'b0); expect_cmd(3, 16'h6003, 1'b0);
    expect_cmd(0, 16'h6000, 1'b0); expect_cmd(1, 16'h6001, 1'b0);
    wait_cmds("mid_fill");
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_outputs",
          64'({ram_cmd_valid, req_cmd_ready, req_resp_valid, ram_resp_ready}), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    resp_budget = BIG;
    @(negedge clk);
    check("post_rst_resp", 64'({req_resp_valid, ram_resp_ready}), 64'd0);
`ifdef TAXI_DMA_RAM_RD_ARB_STATUS_EN
    check("post_rst_stat", 64'({stat_outstanding, stat_port_busy}), 64'd0);
`endif
    @(posedge clk); #2;
    issue(3, 16'h7003);
    issue(0, 16'h7000);
    expect_cmd(0, 16'h7000, 1'b1);
    expect_cmd(3, 16'h7003, 1'b1);
    wait_drain("post_rst_drain");

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_taxi_dma_ram_rd_arb
`default_nettype wire
